// File: rtl/cmos_pixel_packer_if.sv
// Sensor-side and pixel-side signal bundle for cmos_pixel_packer.
// Latency: none (wires only).
// Backpressure: none; both sides are free-running at the pixel clock.
interface cmos_pixel_packer_if #(
    parameter int IN_W      = 8,
    parameter int PIX_BYTES = 2
);
    logic                      vs_i;
    logic                      de_i;
    logic [IN_W-1:0]           data_i;
    logic                      pix_valid;
    logic [IN_W*PIX_BYTES-1:0] pix_data;
    logic                      pix_sof;
    logic                      pix_eol;
    logic                      vs_o;

    modport master (output vs_i, de_i, data_i,
                    input  pix_valid, pix_data, pix_sof, pix_eol, vs_o);
    modport slave  (input  vs_i, de_i, data_i,
                    output pix_valid, pix_data, pix_sof, pix_eol, vs_o);
endinterface

// File: rtl/cmos_pixel_packer.sv
// Packs PIX_BYTES sensor bytes per pixel, drops warm-up frames, checks line/frame geometry.
// Latency: 1 pclk from the completing byte to pix_valid; vs_o and status pulses also lag by 1.
// Backpressure: none; the sensor cannot be stalled, so excess pixels/lines are suppressed.
module cmos_pixel_packer #(
    parameter int IN_W        = 8,
    parameter int PIX_BYTES   = 2,
    parameter int IMAGE_W     = 1280,
    parameter int IMAGE_H     = 720,
    parameter int SKIP_FRAMES = 2,
    parameter int CNT_W       = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                byte_swap,
    cmos_pixel_packer_if.slave  pix_if,
    output logic                frame_done,
    output logic                line_err,
    output logic                frame_err,
    output logic [15:0]         frame_cnt
);
    localparam int PIX_W = IN_W * PIX_BYTES;
    localparam int IDX_W = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
    localparam int SK_W  = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SKIP, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [SK_W-1:0]  skip_cnt, skip_cnt_nxt;
    logic             vs_r, de_r, fe, line_end, in_active;
    logic             swap_q, sof_pend, err_acc;
    logic [IDX_W-1:0] byte_idx, slot;
    logic [CNT_W-1:0] pix_cnt, line_cnt;
    logic [PIX_W-1:0] pix_buf, pix_word;
    logic             capture, pix_done, pix_emit, line_bad;

    assign fe        = pix_if.vs_i & ~vs_r;
    assign line_end  = ~pix_if.de_i & de_r;
    assign in_active = (state == ACTIVE);

    // Bytes coinciding with a frame edge belong to no line and are ignored.
    assign capture   = in_active & ~fe & pix_if.de_i;
    assign pix_done  = capture && (int'(byte_idx) == PIX_BYTES - 1);
    assign pix_emit  = pix_done && (pix_cnt < CNT_W'(IMAGE_W)) && (line_cnt < CNT_W'(IMAGE_H));
    assign line_bad  = (pix_cnt != CNT_W'(IMAGE_W)) || (byte_idx != '0) ||
                       (line_cnt >= CNT_W'(IMAGE_H));

    always_comb begin
        state_nxt    = state;
        skip_cnt_nxt = skip_cnt;
        if (fe) begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        skip_cnt_nxt = '0;
                        if (SKIP_FRAMES == 0) state_nxt = ACTIVE;
                        else                  state_nxt = SKIP;
                    end
                end
                SKIP: begin
                    if (int'(skip_cnt) + 1 >= SKIP_FRAMES) state_nxt = ACTIVE;
                    else skip_cnt_nxt = skip_cnt + SK_W'(1);
                end
                ACTIVE: begin
                    if (!enable) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Slot 0 is the MS byte; swap mirrors the slot order.
    always_comb begin
        slot     = swap_q ? (IDX_W'(PIX_BYTES - 1) - byte_idx) : byte_idx;
        pix_word = pix_buf;
        pix_word[(PIX_BYTES - 1 - int'(slot)) * IN_W +: IN_W] = pix_if.data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            skip_cnt         <= '0;
            vs_r             <= 1'b0;
            de_r             <= 1'b0;
            swap_q           <= 1'b0;
            sof_pend         <= 1'b0;
            err_acc          <= 1'b0;
            byte_idx         <= '0;
            pix_cnt          <= '0;
            line_cnt         <= '0;
            pix_buf          <= '0;
            pix_if.pix_valid <= 1'b0;
            pix_if.pix_data  <= '0;
            pix_if.pix_sof   <= 1'b0;
            pix_if.pix_eol   <= 1'b0;
            pix_if.vs_o      <= 1'b0;
            frame_done       <= 1'b0;
            line_err         <= 1'b0;
            frame_err        <= 1'b0;
            frame_cnt        <= '0;
        end else begin
            state            <= state_nxt;
            skip_cnt         <= skip_cnt_nxt;
            vs_r             <= pix_if.vs_i;
            de_r             <= pix_if.de_i;
            pix_if.vs_o      <= pix_if.vs_i;
            pix_if.pix_valid <= pix_emit;
            pix_if.pix_sof   <= pix_emit & sof_pend;
            pix_if.pix_eol   <= pix_emit && (pix_cnt == CNT_W'(IMAGE_W - 1));
            frame_done       <= 1'b0;
            frame_err        <= 1'b0;
            line_err         <= 1'b0;
            if (pix_emit) begin
                pix_if.pix_data <= pix_word;
                sof_pend        <= 1'b0;
            end
            if (fe) begin
                swap_q   <= byte_swap;
                byte_idx <= '0;
                pix_cnt  <= '0;
                line_cnt <= '0;
                err_acc  <= 1'b0;
                sof_pend <= (state_nxt == ACTIVE);
                if (in_active) begin
                    frame_done <= 1'b1;
                    frame_err  <= (line_cnt != CNT_W'(IMAGE_H)) || err_acc || de_r;
                    frame_cnt  <= frame_cnt + 16'd1;
                end
            end else if (in_active) begin
                if (line_end) begin
                    byte_idx <= '0;
                    pix_cnt  <= '0;
                    if (line_cnt != '1) line_cnt <= line_cnt + CNT_W'(1);
                    line_err <= line_bad;
                    err_acc  <= err_acc | line_bad;
                end else if (capture) begin
                    pix_buf <= pix_word;
                    if (pix_done) begin
                        byte_idx <= '0;
                        if (pix_cnt != '1) pix_cnt <= pix_cnt + CNT_W'(1);
                    end else begin
                        byte_idx <= byte_idx + IDX_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Bench for cmos_pixel_packer: three parameterisations (2-byte, 2-byte with two skip frames,
// 3-byte) fed from one shared sensor stream, each with its own enable.
module tb_cmos_pixel_packer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs = 1'b0, de = 1'b0, bs = 1'b0;
    logic [7:0] dat = 8'h00;
    logic       en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    int         n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    cmos_pixel_packer_if #(.IN_W(8), .PIX_BYTES(2)) if_a ();
    cmos_pixel_packer_if #(.IN_W(8), .PIX_BYTES(2)) if_b ();
    cmos_pixel_packer_if #(.IN_W(8), .PIX_BYTES(3)) if_c ();

    assign if_a.vs_i = vs;  assign if_a.de_i = de;  assign if_a.data_i = dat;
    assign if_b.vs_i = vs;  assign if_b.de_i = de;  assign if_b.data_i = dat;
    assign if_c.vs_i = vs;  assign if_c.de_i = de;  assign if_c.data_i = dat;

    logic fd_a, le_a, fe_a, fd_b, le_b, fe_b, fd_c, le_c, fe_c;
    logic [15:0] fc_a, fc_b, fc_c;

    cmos_pixel_packer #(.IN_W(8), .PIX_BYTES(2), .IMAGE_W(4), .IMAGE_H(2), .SKIP_FRAMES(0), .CNT_W(4))
        dut_a (.clk(clk), .rst(rst), .enable(en_a), .byte_swap(bs), .pix_if(if_a.slave),
               .frame_done(fd_a), .line_err(le_a), .frame_err(fe_a), .frame_cnt(fc_a));
    cmos_pixel_packer #(.IN_W(8), .PIX_BYTES(2), .IMAGE_W(4), .IMAGE_H(2), .SKIP_FRAMES(2), .CNT_W(4))
        dut_b (.clk(clk), .rst(rst), .enable(en_b), .byte_swap(bs), .pix_if(if_b.slave),
               .frame_done(fd_b), .line_err(le_b), .frame_err(fe_b), .frame_cnt(fc_b));
    cmos_pixel_packer #(.IN_W(8), .PIX_BYTES(3), .IMAGE_W(4), .IMAGE_H(2), .SKIP_FRAMES(0), .CNT_W(4))
        dut_c (.clk(clk), .rst(rst), .enable(en_c), .byte_swap(bs), .pix_if(if_c.slave),
               .frame_done(fd_c), .line_err(le_c), .frame_err(fe_c), .frame_cnt(fc_c));

    // Output logs, sampled on the falling edge.
    logic [31:0] px_a[$], px_b[$], px_c[$];
    logic        sof_a[$], eol_a[$], sof_b[$], eol_b[$], sof_c[$], eol_c[$];
    int          lerr_a, lerr_b, lerr_c, fdn_a, fdn_b, fdn_c;
    logic        ferr_a, ferr_b, ferr_c;

    always @(negedge clk) begin
        if (if_a.pix_valid) begin
            px_a.push_back(32'(if_a.pix_data)); sof_a.push_back(if_a.pix_sof); eol_a.push_back(if_a.pix_eol);
        end
        if (if_b.pix_valid) begin
            px_b.push_back(32'(if_b.pix_data)); sof_b.push_back(if_b.pix_sof); eol_b.push_back(if_b.pix_eol);
        end
        if (if_c.pix_valid) begin
            px_c.push_back(32'(if_c.pix_data)); sof_c.push_back(if_c.pix_sof); eol_c.push_back(if_c.pix_eol);
        end
        if (le_a) lerr_a++;
        if (le_b) lerr_b++;
        if (le_c) lerr_c++;
        if (fd_a) begin fdn_a++; ferr_a = fe_a; end
        if (fd_b) begin fdn_b++; ferr_b = fe_b; end
        if (fd_c) begin fdn_c++; ferr_c = fe_c; end
    end

    task automatic clear_logs();
        px_a.delete(); sof_a.delete(); eol_a.delete();
        px_b.delete(); sof_b.delete(); eol_b.delete();
        px_c.delete(); sof_c.delete(); eol_c.delete();
        lerr_a = 0; lerr_b = 0; lerr_c = 0;
        fdn_a = 0; fdn_b = 0; fdn_c = 0;
        ferr_a = 1'b0; ferr_b = 1'b0; ferr_c = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_fe();
        vs = 1'b1; idle(2); vs = 1'b0; idle(2);
    endtask

    task automatic send_line(input int n, input logic [7:0] base, input logic [7:0] inc);
        for (int i = 0; i < n; i++) begin
            de = 1'b1; dat = base + 8'(i) * inc; step();
        end
        de = 1'b0; dat = 8'h00; idle(3);
    endtask

    task automatic test_reset();
        vs = 1'b1; idle(2); vs = 1'b0;
        n_tests++;
        if ({if_a.pix_valid, if_a.pix_sof, if_a.pix_eol, if_a.vs_o, fd_a, le_a, fe_a} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000000",
                {if_a.pix_valid, if_a.pix_sof, if_a.pix_eol, if_a.vs_o, fd_a, le_a, fe_a});
        end
        n_tests++;
        if (if_a.pix_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", if_a.pix_data); end
        n_tests++;
        if (fc_a !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", fc_a); end
        rst = 1'b0; idle(2);
    endtask

    task automatic test_basic();
        logic [31:0] exp_px [8] = '{32'h1112, 32'h1314, 32'h1516, 32'h1718,
                                    32'h1112, 32'h1314, 32'h1516, 32'h1718};
        en_a = 1'b1; bs = 1'b0;
        send_fe(); clear_logs();
        send_line(8, 8'h11, 8'h01); send_line(8, 8'h11, 8'h01);
        send_fe();
        n_tests++;
        if (px_a.size() !== 8) begin n_fail++; $display("FAIL basic_count: got %0d want 8", px_a.size()); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (px_a[i] !== exp_px[i]) begin n_fail++; $display("FAIL basic_pix%0d: got %h want %h", i, px_a[i], exp_px[i]); end
        end
        n_tests++;
        if ({sof_a[0], sof_a[4]} !== 2'b10) begin n_fail++; $display("FAIL basic_sof: got %b want 10", {sof_a[0], sof_a[4]}); end
        n_tests++;
        if ({eol_a[2], eol_a[3], eol_a[7]} !== 3'b011) begin
            n_fail++; $display("FAIL basic_eol: got %b want 011", {eol_a[2], eol_a[3], eol_a[7]});
        end
        n_tests++;
        if (lerr_a !== 0) begin n_fail++; $display("FAIL basic_line_err: got %0d want 0", lerr_a); end
        n_tests++;
        if ({fdn_a, ferr_a} !== {32'd1, 1'b0}) begin n_fail++; $display("FAIL basic_done: got %0d/%b want 1/0", fdn_a, ferr_a); end
        n_tests++;
        if (fc_a !== 16'd1) begin n_fail++; $display("FAIL basic_frame_cnt: got %0d want 1", fc_a); end
    endtask

    task automatic test_swap();
        bs = 1'b1; clear_logs();
        send_fe();
        n_tests++;
        if ({fdn_a, ferr_a, fc_a} !== {32'd1, 1'b1, 16'd2}) begin
            n_fail++; $display("FAIL empty_frame: got %0d/%b/%0d want 1/1/2", fdn_a, ferr_a, fc_a);
        end
        clear_logs();
        send_line(8, 8'h11, 8'h01); send_line(8, 8'h11, 8'h01);
        send_fe();
        n_tests++;
        if (px_a.size() !== 8) begin n_fail++; $display("FAIL swap_count: got %0d want 8", px_a.size()); end
        n_tests++;
        if (px_a[0] !== 32'h1211) begin n_fail++; $display("FAIL swap_pix0: got %h want 1211", px_a[0]); end
        n_tests++;
        if (px_a[3] !== 32'h1817) begin n_fail++; $display("FAIL swap_pix3: got %h want 1817", px_a[3]); end
        n_tests++;
        if ({ferr_a, fc_a} !== {1'b0, 16'd3}) begin n_fail++; $display("FAIL swap_done: got %b/%0d want 0/3", ferr_a, fc_a); end
    endtask

    task automatic test_skip();
        en_a = 1'b0; bs = 1'b0; en_b = 1'b1; clear_logs();
        send_fe();
        send_line(8, 8'h11, 8'h01); send_line(8, 8'h11, 8'h01);
        send_fe();
        send_line(8, 8'h11, 8'h01); send_line(8, 8'h11, 8'h01);
        send_fe();
        n_tests++;
        if ({px_b.size(), fdn_b} !== {32'd0, 32'd0}) begin
            n_fail++; $display("FAIL skip_quiet: got %0d px %0d done want 0 0", px_b.size(), fdn_b);
        end
        send_line(8, 8'h11, 8'h01); send_line(8, 8'h11, 8'h01);
        en_b = 1'b0;
        send_fe();
        n_tests++;
        if (px_b.size() !== 8) begin n_fail++; $display("FAIL skip_count: got %0d want 8", px_b.size()); end
        n_tests++;
        if ({px_b[0], sof_b[0]} !== {32'h1112, 1'b1}) begin
            n_fail++; $display("FAIL skip_first: got %h/%b want 1112/1", px_b[0], sof_b[0]);
        end
        n_tests++;
        if ({fdn_b, ferr_b, fc_b} !== {32'd1, 1'b0, 16'd1}) begin
            n_fail++; $display("FAIL skip_done: got %0d/%b/%0d want 1/0/1", fdn_b, ferr_b, fc_b);
        end
        n_tests++;
        if (fc_a !== 16'd4) begin n_fail++; $display("FAIL skip_a_cnt: got %0d want 4", fc_a); end
    endtask

    task automatic test_line_err();
        en_a = 1'b1;
        send_fe(); clear_logs();
        send_line(7, 8'h11, 8'h01);
        send_line(10, 8'h11, 8'h01);
        en_a = 1'b0;
        send_fe();
        n_tests++;
        if (px_a.size() !== 7) begin n_fail++; $display("FAIL lerr_count: got %0d want 7", px_a.size()); end
        n_tests++;
        if ({px_a[2], px_a[3], px_a[6]} !== {32'h1516, 32'h1112, 32'h1718}) begin
            n_fail++; $display("FAIL lerr_pix: got %h %h %h want 1516 1112 1718", px_a[2], px_a[3], px_a[6]);
        end
        n_tests++;
        if ({eol_a[2], eol_a[6]} !== 2'b01) begin n_fail++; $display("FAIL lerr_eol: got %b want 01", {eol_a[2], eol_a[6]}); end
        n_tests++;
        if (lerr_a !== 2) begin n_fail++; $display("FAIL lerr_pulses: got %0d want 2", lerr_a); end
        n_tests++;
        if ({fdn_a, ferr_a, fc_a} !== {32'd1, 1'b1, 16'd5}) begin
            n_fail++; $display("FAIL lerr_done: got %0d/%b/%0d want 1/1/5", fdn_a, ferr_a, fc_a);
        end
    endtask

    task automatic test_pb3();
        en_c = 1'b1;
        send_fe(); clear_logs();
        for (int i = 0; i < 12; i++) begin
            de = 1'b1; dat = 8'hAA + 8'(i) * 8'h11; step();
            if (i == 1) begin
                n_tests++;
                if (if_c.pix_valid !== 1'b0) begin n_fail++; $display("FAIL pb3_early: got %b want 0", if_c.pix_valid); end
            end
            if (i == 2) begin
                n_tests++;
                if ({if_c.pix_valid, if_c.pix_data} !== {1'b1, 24'hAABBCC}) begin
                    n_fail++; $display("FAIL pb3_first: got %b/%h want 1/aabbcc", if_c.pix_valid, if_c.pix_data);
                end
            end
        end
        de = 1'b0; idle(3);
        en_c = 1'b0;
        send_line(12, 8'hAA, 8'h11);
        send_fe();
        n_tests++;
        if (px_c.size() !== 8) begin n_fail++; $display("FAIL pb3_count: got %0d want 8", px_c.size()); end
        n_tests++;
        if ({px_c[2], px_c[7]} !== {32'h102132, 32'h435465}) begin
            n_fail++; $display("FAIL pb3_pix: got %h %h want 102132 435465", px_c[2], px_c[7]);
        end
        n_tests++;
        if ({fdn_c, ferr_c, fc_c} !== {32'd1, 1'b0, 16'd1}) begin
            n_fail++; $display("FAIL pb3_done: got %0d/%b/%0d want 1/0/1", fdn_c, ferr_c, fc_c);
        end
        clear_logs();
        send_line(12, 8'hAA, 8'h11); send_line(12, 8'hAA, 8'h11);
        send_fe();
        n_tests++;
        if ({px_c.size(), fdn_c} !== {32'd0, 32'd0}) begin
            n_fail++; $display("FAIL pb3_idle: got %0d px %0d done want 0 0", px_c.size(), fdn_c);
        end
    endtask

    task automatic test_reset_mid();
        en_a = 1'b1;
        send_fe();
        de = 1'b1; dat = 8'h11; step();
        dat = 8'h12; step();
        n_tests++;
        if (if_a.pix_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b want 1", if_a.pix_valid); end
        rst = 1'b1; de = 1'b0; #1;
        n_tests++;
        if ({if_a.pix_valid, if_a.pix_sof, if_a.pix_data, fc_a} !== {2'b00, 16'h0000, 16'd0}) begin
            n_fail++; $display("FAIL mid_reset: got %b/%b/%h/%0d want 0/0/0000/0",
                if_a.pix_valid, if_a.pix_sof, if_a.pix_data, fc_a);
        end
        idle(2); rst = 1'b0; idle(2);
        clear_logs();
        send_line(8, 8'h11, 8'h01);
        n_tests++;
        if (px_a.size() !== 0) begin n_fail++; $display("FAIL mid_no_fe: got %0d want 0", px_a.size()); end
        send_fe();
        send_line(8, 8'h11, 8'h01);
        n_tests++;
        if ({px_a.size(), px_a[0], sof_a[0]} !== {32'd4, 32'h1112, 1'b1}) begin
            n_fail++; $display("FAIL mid_resume: got %0d/%h/%b want 4/1112/1", px_a.size(), px_a[0], sof_a[0]);
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_basic();
        test_swap();
        test_skip();
        test_line_err();
        test_pb3();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cmos_pixel_packer.md
Name: cmos_pixel_packer

Overview:
Parametrised successor to the fixed 8-to-16-bit camera byte combiner in the OV5640 capture path. Packs PIX_BYTES consecutive sensor bytes into one pixel word, with runtime byte-order select. Discards the first SKIP_FRAMES unstable frames after enable and checks line and frame geometry against IMAGE_W/IMAGE_H. Sits between the sensor input delay registers and the dual-camera mixer/frame-buffer writer, in the pixel clock domain.

Parameters:
IN_W, 8, sensor data bus width in bits
PIX_BYTES, 2, input words per pixel; legal range 1..4
IMAGE_W, 1280, expected pixels per line
IMAGE_H, 720, expected lines per frame
SKIP_FRAMES, 2, complete frames discarded after enable; 0 is legal
CNT_W, 12, width of the pixel and line counters; must satisfy 2^CNT_W > max(IMAGE_W, IMAGE_H)

Ports:
clk  in  1  pixel clock (camera pclk)
rst  in  1  reset; asynchronous, active-high
enable  in  1  capture enable; sampled only at frame boundaries
byte_swap  in  1  0: first byte of a pixel is the MS byte; 1: first byte is the LS byte; sampled at frame start
vs_i  in  1  vertical sync, active-high; frame boundary is its rising edge
de_i  in  1  byte valid (href)
data_i  in  IN_W  sensor byte
pix_valid  out  1  pixel strobe
pix_data  out  IN_W*PIX_BYTES  packed pixel
pix_sof  out  1  qualifies the first pixel of a frame
pix_eol  out  1  qualifies pixel index IMAGE_W-1 of a line
vs_o  out  1  vs_i delayed to stay aligned with the pixel outputs
frame_done  out  1  one-cycle pulse when an ACTIVE frame closes
line_err  out  1  one-cycle pulse on a line geometry error
frame_err  out  1  valid only while frame_done is high
frame_cnt  out  16  count of frame_done pulses; wraps modulo 2^16

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE. Reset mid-frame aborts immediately; there is no recovery or flush.
- Edge detection: vs_r and de_r are the vs_i and de_i values from the previous cycle. A frame edge (fe) is vs_i=1 and vs_r=0. A line end is de_i=0 and de_r=1.
- vs_o equals vs_i delayed by 1 cycle, which matches the pix_valid latency.
- State machine:
  - IDLE -> SKIP on fe with enable=1. On entry, skip_cnt=0.
  - SKIP: each fe increments skip_cnt. When skip_cnt reaches SKIP_FRAMES, go to ACTIVE on that same fe. With SKIP_FRAMES=0, IDLE goes directly to ACTIVE on the first fe.
  - ACTIVE: on fe, emit frame_done. Then stay in ACTIVE if enable=1; otherwise go to IDLE.
  - enable is ignored between frame edges.
- Packing, ACTIVE only:
  - byte_idx clears at line end and at fe.
  - Each cycle with de_i=1 stores data_i into slot byte_idx, or into slot PIX_BYTES-1-byte_idx when byte_swap=1. Slot k occupies bits [(PIX_BYTES-1-k)*IN_W +: IN_W], so slot 0 is the MS byte.
  - When the byte completing a pixel is sampled, pix_valid=1 on the next cycle with the full word on pix_data. Latency is 1 cycle; throughput is one pixel per PIX_BYTES bytes.
  - pix_data holds its last value when pix_valid=0.
- Line checks:
  - pix_cnt counts emitted pixels within the line. Pixels with pix_cnt >= IMAGE_W are suppressed (no pix_valid).
  - At line end, line_err pulses (1 cycle later, aligned with vs_o timing) if pix_cnt != IMAGE_W or byte_idx != 0. Partial pixel bytes are discarded.
  - line_cnt increments at each line end. Lines with line_cnt >= IMAGE_H are fully suppressed and still produce line_err.
- pix_sof=1 with the first pix_valid after entry into or re-arm of ACTIVE at fe. pix_eol=1 with the pix_valid where pix_cnt = IMAGE_W-1.
- Frame close at fe in ACTIVE:
  - frame_err = (line_cnt != IMAGE_H) OR any line_err during the frame OR de_r=1 at the fe (a line cut off by vsync).
  - frame_cnt increments. line_cnt, pix_cnt and the error accumulator clear.
- An fe arriving while de_i=1 aborts the line: the pending partial pixel is dropped and no line-end check runs for that line.
- In IDLE and SKIP, pix_valid, pix_sof, pix_eol and line_err are held at 0.

Test Plan:
1. PIX_BYTES=2, IMAGE_W=4, IMAGE_H=2, SKIP_FRAMES=0, enable=1, byte_swap=0. Send fe, then 2 lines of bytes 0x11..0x18 -> pix_data 0x1112, 0x1314, 0x1516, 0x1718 per line. pix_sof on the first pixel, pix_eol on the 4th. Next fe -> frame_done=1, frame_err=0, frame_cnt=1.
2. Same as scenario 1 with byte_swap=1 -> first pixel 0x1211.
3. SKIP_FRAMES=2. Send 3 frames -> no pix_valid during frames 1-2; frame 3 is output; frame_done fires only at the 4th fe.
4. A line of 7 bytes -> 3 pixels out, line_err pulse, and frame_err=1 at the next fe. A line of 10 bytes -> 4 pixels out (5th suppressed), line_err=1.
5. PIX_BYTES=3, IN_W=8. Bytes 0xAA, 0xBB, 0xCC -> pix_data 0xAABBCC one cycle after 0xCC is sampled. Deassert enable mid-frame -> the frame completes, then state IDLE with no further output.
6. Assert rst mid-line -> all outputs 0 immediately. After release, no output until enable=1 and a new fe.
